// File: rtl/pll_rate_ctrl_if.sv
// Rate-change request/ack handshake between PHY rate negotiation and PLL rate controller.
// Ports: rate_req/rate_ratio (requester->ctrl), rate_ack/rate_err (ctrl->requester).
interface pll_rate_ctrl_if;
  logic       rate_req;
  logic [7:0] rate_ratio;
  logic       rate_ack;
  logic       rate_err;

  modport master (
    output rate_req,
    output rate_ratio,
    input  rate_ack,
    input  rate_err
  );

  modport slave (
    input  rate_req,
    input  rate_ratio,
    output rate_ack,
    output rate_err
  );
endinterface

// File: rtl/pll_rate_ctrl.sv
// TX PLL rate controller: PLL reset sequencing, settle timing and rate-change handshake.
// Ports: Ref_Clk, rst (sync high), rate (slave handshake), pll_rst_n, pll_div_ratio, pll_ready, busy.
module pll_rate_ctrl #(
  parameter int         RST_CYCLES    = 4,
  parameter int         SETTLE_CYCLES = 16,
  parameter logic [7:0] DEFAULT_RATIO = 8'd20,
  parameter int         CNT_W         = 8
) (
  input  logic                Ref_Clk,
  input  logic                rst,
  pll_rate_ctrl_if.slave      rate,
  output logic                pll_rst_n,
  output logic [7:0]          pll_div_ratio,
  output logic                pll_ready,
  output logic                busy
);

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    SETTLE = 2'd1,
    READY  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             pend_vld;
  logic [7:0]       pend_ratio;

  logic             req_ok;
  logic             req_bad;
  logic             eff_vld;
  logic [7:0]       eff_ratio;

  assign req_ok  = rate.rate_req && (rate.rate_ratio != 8'd0);
  assign req_bad = rate.rate_req && (rate.rate_ratio == 8'd0);

  // Pending view including a request sampled on this same edge,
  // so a request landing on the last SETTLE cycle is not lost.
  always_comb begin
    eff_vld   = pend_vld;
    eff_ratio = pend_ratio;
    if (req_ok) begin
      eff_vld   = 1'b1;
      eff_ratio = rate.rate_ratio;
    end
  end

  always_ff @(posedge Ref_Clk) begin
    if (rst) begin
      state         <= HOLD;
      cnt           <= '0;
      pend_vld      <= 1'b0;
      pend_ratio    <= '0;
      pll_rst_n     <= 1'b0;
      pll_div_ratio <= DEFAULT_RATIO;
      pll_ready     <= 1'b0;
      busy          <= 1'b1;
      rate.rate_ack <= 1'b0;
      rate.rate_err <= 1'b0;
    end else begin
      rate.rate_ack <= req_ok;
      rate.rate_err <= req_bad;
      unique case (state)
        HOLD: begin
          pend_vld   <= eff_vld;
          pend_ratio <= eff_ratio;
          if (cnt == RST_LAST) begin
            state     <= SETTLE;
            cnt       <= '0;
            pll_rst_n <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SETTLE: begin
          if (cnt == SET_LAST) begin
            cnt      <= '0;
            pend_vld <= 1'b0;
            // Relock replaces the ready edge, so pll_ready never glitches.
            if (eff_vld && (eff_ratio != pll_div_ratio)) begin
              state         <= HOLD;
              pll_div_ratio <= eff_ratio;
              pll_rst_n     <= 1'b0;
            end else begin
              state     <= READY;
              pll_ready <= 1'b1;
              busy      <= 1'b0;
            end
          end else begin
            cnt        <= cnt + 1'b1;
            pend_vld   <= eff_vld;
            pend_ratio <= eff_ratio;
          end
        end
        READY: begin
          if (req_ok && (rate.rate_ratio != pll_div_ratio)) begin
            state         <= HOLD;
            cnt           <= '0;
            pll_div_ratio <= rate.rate_ratio;
            pll_rst_n     <= 1'b0;
            pll_ready     <= 1'b0;
            busy          <= 1'b1;
          end
        end
        default: begin
          state     <= HOLD;
          cnt       <= '0;
          pend_vld  <= 1'b0;
          pll_rst_n <= 1'b0;
          pll_ready <= 1'b0;
          busy      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_rate_ctrl.sv
// Self-checking bench for pll_rate_ctrl: directed table, corner sequences, random vs model.
// No ports; drives the handshake interface and compares all outputs every cycle.
module tb_pll_rate_ctrl;

  localparam int RST_C = 4;
  localparam int SET_C = 16;
  localparam logic [7:0] DEF = 8'd20;

  logic       Ref_Clk = 1'b0;
  logic       rst;
  logic       pll_rst_n;
  logic [7:0] pll_div_ratio;
  logic       pll_ready;
  logic       busy;

  pll_rate_ctrl_if bus ();

  pll_rate_ctrl #(
    .RST_CYCLES   (RST_C),
    .SETTLE_CYCLES(SET_C),
    .DEFAULT_RATIO(DEF),
    .CNT_W        (8)
  ) dut (
    .Ref_Clk      (Ref_Clk),
    .rst          (rst),
    .rate         (bus.slave),
    .pll_rst_n    (pll_rst_n),
    .pll_div_ratio(pll_div_ratio),
    .pll_ready    (pll_ready),
    .busy         (busy)
  );

  always #5 Ref_Clk = ~Ref_Clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: time since the last lock attempt began, plus a
  // list of ratios requested while busy (only the newest one matters).
  int         m_age;
  bit         m_locked;
  logic [7:0] m_ratio;
  logic [7:0] m_q[$];
  logic       m_ack;
  logic       m_err;

  task automatic model(input bit r, input bit q, input logic [7:0] ra);
    if (r) begin
      m_age = 0; m_locked = 0; m_ratio = DEF;
      m_q.delete(); m_ack = 0; m_err = 0;
      return;
    end
    m_ack = q && (ra != 0);
    m_err = q && (ra == 0);
    if (m_locked) begin
      if (m_ack && ra != m_ratio) begin
        m_ratio = ra; m_locked = 0; m_age = 0;
      end
    end else begin
      if (m_ack) m_q.push_back(ra);
      m_age++;
      if (m_age == RST_C + SET_C) begin
        if (m_q.size() > 0 && m_q[m_q.size()-1] != m_ratio) begin
          m_ratio = m_q[m_q.size()-1];
          m_age = 0;
        end else begin
          m_locked = 1;
        end
        m_q.delete();
      end
    end
  endtask

  task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  task automatic step(input bit r, input bit q, input logic [7:0] ra);
    rst = r; bus.rate_req = q; bus.rate_ratio = ra;
    @(posedge Ref_Clk); #1;
    model(r, q, ra);
    chk("ack",   {7'd0, bus.rate_ack}, {7'd0, m_ack});
    chk("err",   {7'd0, bus.rate_err}, {7'd0, m_err});
    chk("rst_n", {7'd0, pll_rst_n},
        {7'd0, (m_locked || m_age >= RST_C) ? 1'b1 : 1'b0});
    chk("ready", {7'd0, pll_ready}, {7'd0, m_locked});
    chk("busy",  {7'd0, busy}, {7'd0, ~m_locked});
    chk("ratio", pll_div_ratio, m_ratio);
    rst = 0; bus.rate_req = 0;
  endtask

  task automatic run(input int n, input bit r, input bit q, input logic [7:0] ra);
    for (int i = 0; i < n; i++) step(r, q, ra);
  endtask

  task automatic outs(input string n, input bit ack, input bit err, input bit rn,
                      input bit rdy, input bit bz, input logic [7:0] div);
    chk({n, ".ack"},   {7'd0, bus.rate_ack}, {7'd0, ack});
    chk({n, ".err"},   {7'd0, bus.rate_err}, {7'd0, err});
    chk({n, ".rst_n"}, {7'd0, pll_rst_n}, {7'd0, rn});
    chk({n, ".ready"}, {7'd0, pll_ready}, {7'd0, rdy});
    chk({n, ".busy"},  {7'd0, busy}, {7'd0, bz});
    chk({n, ".div"},   pll_div_ratio, div);
  endtask

  typedef struct {
    int         n;
    bit         r;
    bit         q;
    logic [7:0] ra;
    bit         ack;
    bit         err;
    bit         rn;
    bit         rdy;
    bit         bz;
    logic [7:0] div;
  } vec_t;

  vec_t tbl[12];
  bit   seen_ready;
  int   pick;
  logic [7:0] rr;

  initial begin
    rst = 1; bus.rate_req = 0; bus.rate_ratio = 0;
    m_age = 0; m_locked = 0; m_ratio = DEF; m_ack = 0; m_err = 0;

    //           n   r  q  ra   ack err rn rdy bz div
    tbl[0]  = '{ 2, 1, 0, 8'd0, 0, 0, 0, 0, 1, 8'd20};
    tbl[1]  = '{ 3, 0, 0, 8'd0, 0, 0, 0, 0, 1, 8'd20};
    tbl[2]  = '{ 1, 0, 0, 8'd0, 0, 0, 1, 0, 1, 8'd20};
    tbl[3]  = '{15, 0, 0, 8'd0, 0, 0, 1, 0, 1, 8'd20};
    tbl[4]  = '{ 1, 0, 0, 8'd0, 0, 0, 1, 1, 0, 8'd20};
    tbl[5]  = '{ 1, 0, 1, 8'd0, 0, 1, 1, 1, 0, 8'd20};
    tbl[6]  = '{ 1, 0, 1, 8'd20,1, 0, 1, 1, 0, 8'd20};
    tbl[7]  = '{ 1, 0, 1, 8'd40,1, 0, 0, 0, 1, 8'd40};
    tbl[8]  = '{ 3, 0, 0, 8'd0, 0, 0, 0, 0, 1, 8'd40};
    tbl[9]  = '{ 1, 0, 0, 8'd0, 0, 0, 1, 0, 1, 8'd40};
    tbl[10] = '{15, 0, 0, 8'd0, 0, 0, 1, 0, 1, 8'd40};
    tbl[11] = '{ 1, 0, 0, 8'd0, 0, 0, 1, 1, 0, 8'd40};

    for (int i = 0; i < 12; i++) begin
      run(tbl[i].n, tbl[i].r, tbl[i].q, tbl[i].ra);
      outs($sformatf("tbl%0d", i), tbl[i].ack, tbl[i].err, tbl[i].rn,
           tbl[i].rdy, tbl[i].bz, tbl[i].div);
    end

    // Two requests during SETTLE: relock to the last one, no ready pulse.
    step(0, 1, 8'd60);
    seen_ready = 0;
    for (int i = 0; i < 5; i++) begin step(0, 0, 0); seen_ready |= pll_ready; end
    step(0, 1, 8'd30); seen_ready |= pll_ready;
    step(0, 1, 8'd50); seen_ready |= pll_ready;
    for (int i = 0; i < 13; i++) begin step(0, 0, 0); seen_ready |= pll_ready; end
    outs("pend_relock", 0, 0, 0, 0, 1, 8'd50);
    for (int i = 0; i < 19; i++) begin step(0, 0, 0); seen_ready |= pll_ready; end
    chk("no_ready_glitch", {7'd0, seen_ready}, 8'd0);
    step(0, 0, 0);
    outs("pend_ready", 0, 0, 1, 1, 0, 8'd50);

    // Same-ratio request during SETTLE: ordinary READY entry.
    step(0, 1, 8'd70);
    run(5, 0, 0, 0);
    step(0, 1, 8'd70);
    run(14, 0, 0, 0);
    outs("same_pend", 0, 0, 1, 1, 0, 8'd70);

    // Reset mid-SETTLE with a pending request; reset also masks a request.
    step(0, 1, 8'd40);
    run(8, 0, 0, 0);
    step(0, 1, 8'd90);
    step(1, 1, 8'd33);
    outs("rst_mid", 0, 0, 0, 0, 1, 8'd20);
    run(4, 0, 0, 0);
    chk("rebring_rst_n", {7'd0, pll_rst_n}, 8'd1);
    run(15, 0, 0, 0);
    chk("rebring_nrdy", {7'd0, pll_ready}, 8'd0);
    step(0, 0, 0);
    outs("rebring", 0, 0, 1, 1, 0, 8'd20);

    // Random traffic, including back-to-back requests and stray resets.
    for (int i = 0; i < 3000; i++) begin
      pick = $urandom_range(0, 7);
      rr = (pick == 0) ? 8'd0 :
           (pick == 1) ? m_ratio : 8'($urandom_range(1, 255));
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0), rr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
